// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the IF/ID skid-buffer state encoding.
package mips_pkg;

   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_XORI = 6'h0E;
   localparam logic [5:0] OP_LUI  = 6'h0F;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/sign_ext.sv
// Sign-extends a 16-bit immediate to 32 bits.
module sign_ext (
   input  logic [15:0] a,
   output logic [31:0] res
);

   assign res = {{16{a[15]}}, a};

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: 2-entry skid buffer (head + skid) with instruction
// field decode, immediate extension and branch-target computation on the head.
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc4,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  out_opcode,
   output logic [4:0]  out_rs,
   output logic [4:0]  out_rt,
   output logic [4:0]  out_rd,
   output logic [4:0]  out_shamt,
   output logic [5:0]  out_funct,
   output logic [15:0] out_imm16,
   output logic [31:0] out_imm32,
   output logic [31:0] out_pc4,
   output logic [31:0] out_br_target
);

   buf_state_t  state, state_next;
   logic [31:0] head_instr, head_instr_next;
   logic [31:0] head_pc4, head_pc4_next;
   logic [31:0] skid_instr, skid_instr_next;
   logic [31:0] skid_pc4, skid_pc4_next;
   logic        ready_q;
   logic        push, pop;
   logic [31:0] imm_sext;

   assign in_ready  = ready_q;
   assign out_valid = (state != ST_EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // in_ready is precomputed from the next state so it never depends
   // combinationally on out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_EMPTY;
         ready_q    <= 1'b0;
         head_instr <= NOP_INSTR;
         head_pc4   <= 32'h0;
         skid_instr <= NOP_INSTR;
         skid_pc4   <= 32'h0;
      end else begin
         state      <= state_next;
         ready_q    <= (state_next != ST_FULL);
         head_instr <= head_instr_next;
         head_pc4   <= head_pc4_next;
         skid_instr <= skid_instr_next;
         skid_pc4   <= skid_pc4_next;
      end
   end

   always_comb begin
      state_next      = state;
      head_instr_next = head_instr;
      head_pc4_next   = head_pc4;
      skid_instr_next = skid_instr;
      skid_pc4_next   = skid_pc4;
      if (flush) begin
         state_next      = ST_EMPTY;
         head_instr_next = NOP_INSTR;
         head_pc4_next   = 32'h0;
         skid_instr_next = NOP_INSTR;
         skid_pc4_next   = 32'h0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (push) begin
                  state_next      = ST_ONE;
                  head_instr_next = in_instr;
                  head_pc4_next   = in_pc4;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  head_instr_next = in_instr;
                  head_pc4_next   = in_pc4;
               end else if (push) begin
                  state_next      = ST_FULL;
                  skid_instr_next = in_instr;
                  skid_pc4_next   = in_pc4;
               end else if (pop) begin
                  state_next      = ST_EMPTY;
                  head_instr_next = NOP_INSTR;
                  head_pc4_next   = 32'h0;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  state_next      = ST_ONE;
                  head_instr_next = skid_instr;
                  head_pc4_next   = skid_pc4;
                  skid_instr_next = NOP_INSTR;
                  skid_pc4_next   = 32'h0;
               end
            end
            default: begin
               state_next      = ST_EMPTY;
               head_instr_next = NOP_INSTR;
               head_pc4_next   = 32'h0;
               skid_instr_next = NOP_INSTR;
               skid_pc4_next   = 32'h0;
            end
         endcase
      end
   end

   sign_ext u_sign_ext (
      .a   (head_instr[15:0]),
      .res (imm_sext)
   );

   assign out_opcode    = head_instr[31:26];
   assign out_rs        = head_instr[25:21];
   assign out_rt        = head_instr[20:16];
   assign out_rd        = head_instr[15:11];
   assign out_shamt     = head_instr[10:6];
   assign out_funct     = head_instr[5:0];
   assign out_imm16     = head_instr[15:0];
   assign out_pc4       = head_pc4;
   assign out_br_target = head_pc4 + {imm_sext[29:0], 2'b00};

   // Logical immediates are zero-extended, lui shifts into the upper half.
   always_comb begin
      out_imm32 = imm_sext;
      if (out_opcode == OP_ANDI || out_opcode == OP_ORI || out_opcode == OP_XORI)
         out_imm32 = {16'h0, head_instr[15:0]};
      else if (out_opcode == OP_LUI)
         out_imm32 = {head_instr[15:0], 16'h0};
   end

endmodule
